// File: rtl/coinc_pkg.sv
// Shared definitions for the SRAM read-out path: FSM encoding and default phase timings.
package coinc_pkg;

   localparam int unsigned WAIT_RD_DEF  = 2;
   localparam int unsigned WR_PULSE_DEF = 4;
   localparam int unsigned TXE_HOLD_DEF = 4;

   // One timer serves WAIT, STB and HLD, so every phase length must fit in this width.
   localparam int unsigned TIMER_W = 8;

   typedef enum logic [3:0] {
      StIdle  = 4'd0,
      StSetup = 4'd1,
      StWait  = 4'd2,
      StLatch = 4'd3,
      StTxwL  = 4'd4,
      StStbL  = 4'd5,
      StHldL  = 4'd6,
      StTxwH  = 4'd7,
      StStbH  = 4'd8,
      StHldH  = 4'd9
   } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous FIFO TXE# input.
// It resets to 1, which reads as "FIFO full", so nothing is written right after reset.
module sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/sram_usb_reader.sv
// Read-out engine: streams a block of 16-bit SRAM words, low byte first, into an FT245 USB FIFO.
// All pin outputs are decoded from registered state, so reset clears them asynchronously.
module sram_usb_reader
   import coinc_pkg::*;
#(
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned WAIT_RD  = WAIT_RD_DEF,
   parameter int unsigned WR_PULSE = WR_PULSE_DEF,
   parameter int unsigned TXE_HOLD = TXE_HOLD_DEF
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              START,
   input  logic              ABORT,
   input  logic [ADDR_W-1:0] BASE,
   input  logic [ADDR_W-1:0] LEN,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] ADX,
   input  logic [15:0]       DX,
   output logic              CEX,
   output logic              CEY,
   output logic              CE1,
   output logic              CE2,
   output logic              BHE,
   output logic              BLE,
   output logic [7:0]        USBX_O,
   output logic              USBX_OE,
   output logic              WR,
   input  logic              TXE
);

   localparam logic [TIMER_W-1:0] WaitLoad = TIMER_W'(WAIT_RD - 1);
   localparam logic [TIMER_W-1:0] StbLoad  = TIMER_W'(WR_PULSE - 1);
   localparam logic [TIMER_W-1:0] HldLoad  = TIMER_W'(TXE_HOLD - 1);

   state_e              r_state;
   logic [TIMER_W-1:0]  r_timer;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_cnt;
   logic [15:0]         r_word;
   logic                r_abort;
   logic                r_done;

   state_e              w_state_nxt;
   logic [TIMER_W-1:0]  w_timer_nxt;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic [15:0]         w_word_nxt;
   logic                w_abort_nxt;
   logic                w_done_nxt;
   logic                w_abort_any;
   logic                w_txe_sync;
   logic                w_sram_act;
   logic                w_timer_zero;

   sync2 u_txe_sync (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_d     (TXE),
      .o_q     (w_txe_sync)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= StIdle;
         r_timer <= '0;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_word  <= '0;
         r_abort <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_addr  <= w_addr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_word  <= w_word_nxt;
         r_abort <= w_abort_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign w_abort_any  = r_abort | ABORT;
   assign w_timer_zero = (r_timer == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      w_word_nxt  = r_word;
      w_abort_nxt = w_abort_any;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_abort_nxt = 1'b0;
            if (START && !ABORT) begin
               w_addr_nxt = BASE;
               w_cnt_nxt  = LEN;
               if (LEN == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = StSetup;
               end
            end
         end
         StSetup: begin
            w_state_nxt = StWait;
            w_timer_nxt = WaitLoad;
         end
         StWait: begin
            if (w_timer_zero) w_state_nxt = StLatch;
            else              w_timer_nxt = r_timer - TIMER_W'(1);
         end
         StLatch: begin
            // The read always completes; a pending abort only stops the USB half.
            w_word_nxt  = DX;
            w_state_nxt = w_abort_any ? StIdle : StTxwL;
         end
         StTxwL, StTxwH: begin
            if (w_abort_any) begin
               w_state_nxt = StIdle;
            end else if (!w_txe_sync) begin
               w_state_nxt = (r_state == StTxwL) ? StStbL : StStbH;
               w_timer_nxt = StbLoad;
            end
         end
         StStbL, StStbH: begin
            if (w_timer_zero) begin
               w_state_nxt = (r_state == StStbL) ? StHldL : StHldH;
               w_timer_nxt = HldLoad;
            end else begin
               w_timer_nxt = r_timer - TIMER_W'(1);
            end
         end
         StHldL: begin
            if (!w_timer_zero)    w_timer_nxt = r_timer - TIMER_W'(1);
            else if (w_abort_any) w_state_nxt = StIdle;
            else                  w_state_nxt = StTxwH;
         end
         StHldH: begin
            if (!w_timer_zero) begin
               w_timer_nxt = r_timer - TIMER_W'(1);
            end else begin
               w_addr_nxt = r_addr + ADDR_W'(1);
               w_cnt_nxt  = r_cnt - ADDR_W'(1);
               if (w_abort_any) begin
                  w_state_nxt = StIdle;
               end else if (r_cnt == ADDR_W'(1)) begin
                  w_state_nxt = StIdle;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = StSetup;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign w_sram_act = (r_state == StSetup) || (r_state == StWait) || (r_state == StLatch);

   assign ADX     = w_sram_act ? r_addr : '0;
   assign CEX     = ~w_sram_act;
   assign CEY     = 1'b1;
   assign CE1     = ~w_sram_act;
   assign CE2     = w_sram_act;
   assign BHE     = ~w_sram_act;
   assign BLE     = ~w_sram_act;
   assign BUSY    = (r_state != StIdle);
   assign DONE    = r_done;
   assign USBX_OE = BUSY;
   assign WR      = (r_state == StStbL) || (r_state == StStbH);

   always_comb begin
      USBX_O = 8'h00;
      unique case (r_state)
         StStbL, StHldL: USBX_O = r_word[7:0];
         StStbH, StHldH: USBX_O = r_word[15:8];
         default:        USBX_O = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_sram_usb_reader.sv
// Scoreboard bench: each transfer's expected SRAM addresses and USB bytes are queued up front,
// and independent monitors drain them on CE1 falls, WR falls and DONE pulses.
module tb_sram_usb_reader;

   localparam int unsigned ADDR_W   = 20;
   localparam int unsigned WAIT_RD  = 2;
   localparam int unsigned WR_PULSE = 4;
   localparam int unsigned TXE_HOLD = 4;
   localparam int          WordCyc  = 2 + WAIT_RD + 2 * (1 + WR_PULSE + TXE_HOLD);
   // {pad, ADX, CEX, CEY, CE1, CE2, BHE, BLE, USBX_O, USBX_OE, WR, BUSY, DONE}
   localparam logic [63:0] RstVec   = {26'h0, 20'h0, 6'b111011, 8'h00, 4'b0000};

   logic              clk   = 1'b0;
   logic              rstn  = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              txe   = 1'b0;
   logic [ADDR_W-1:0] base  = '0;
   logic [ADDR_W-1:0] len   = '0;
   logic [15:0]       seed  = 16'h1234;

   logic              busy, done, cex, cey, ce1, ce2, bhe, ble, usbx_oe, wr;
   logic [ADDR_W-1:0] adx;
   logic [15:0]       dx;
   logic [7:0]        usbx_o;

   int errors    = 0;
   int checks    = 0;
   int done_seen = 0;
   logic [7:0]        exp_bytes[$];
   logic [ADDR_W-1:0] exp_addrs[$];

   always #4 clk = ~clk;

   sram_usb_reader #(
      .ADDR_W   (ADDR_W),
      .WAIT_RD  (WAIT_RD),
      .WR_PULSE (WR_PULSE),
      .TXE_HOLD (TXE_HOLD)
   ) dut (
      .CLK     (clk),
      .RSTN    (rstn),
      .START   (start),
      .ABORT   (abort),
      .BASE    (base),
      .LEN     (len),
      .BUSY    (busy),
      .DONE    (done),
      .ADX     (adx),
      .DX      (dx),
      .CEX     (cex),
      .CEY     (cey),
      .CE1     (ce1),
      .CE2     (ce2),
      .BHE     (bhe),
      .BLE     (ble),
      .USBX_O  (usbx_o),
      .USBX_OE (usbx_oe),
      .WR      (wr),
      .TXE     (txe)
   );

   function automatic logic [15:0] word_of(input logic [ADDR_W-1:0] a, input logic [15:0] s);
      if (a == 20'h00010) return 16'hA1B2;
      if (a == 20'h00011) return 16'hC3D4;
      return a[15:0] * 16'h9E37 + s + {12'h0, a[19:16]};
   endfunction

   function automatic logic [63:0] out_vec();
      return {26'h0, adx, cex, cey, ce1, ce2, bhe, ble, usbx_o, usbx_oe, wr, busy, done};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // SRAM model: data is only valid once address and OE have been stable for WAIT_RD+1 cycles.
   logic              sram_act;
   logic [ADDR_W-1:0] sram_addr_q = '0;
   int                sram_cnt    = 0;
   assign sram_act = !ce1 && ce2 && !cex && !bhe && !ble && cey;
   always @(posedge clk) begin
      if (sram_act) sram_cnt <= (adx == sram_addr_q) ? sram_cnt + 1 : 1;
      else          sram_cnt <= 0;
      sram_addr_q <= adx;
   end
   assign dx = (sram_act && sram_cnt >= int'(WAIT_RD) + 1) ? word_of(adx, seed) : 16'hDEAD;

   // Byte monitor: a byte commits on the WR falling edge.
   logic wr_prev  = 1'b0;
   int   wr_width = 0;
   int   txe_run  = 0;
   always @(negedge clk) begin
      if (wr && !wr_prev) check("wr_while_txe_high", 64'(txe_run >= 3), 64'(0));
      if (wr) wr_width++;
      if (wr_prev && !wr) begin
         if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: actual=%0h required=none", usbx_o);
         end else begin
            check("usb_byte", 64'(usbx_o), 64'(exp_bytes.pop_front()));
         end
         check("wr_width", 64'(wr_width), 64'(WR_PULSE));
         wr_width = 0;
      end
      txe_run = txe ? txe_run + 1 : 0;
      wr_prev = wr;
   end

   // Address monitor: one SRAM access per word, address checked on CE1 fall.
   logic ce1_prev = 1'b1;
   always @(negedge clk) begin
      if (ce1_prev && !ce1) begin
         if (exp_addrs.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sram_read: actual=%0h required=none", adx);
         end else begin
            check("sram_addr", 64'(adx), 64'(exp_addrs.pop_front()));
         end
         check("cey_high", 64'(cey), 64'(1));
      end
      ce1_prev = ce1;
   end

   always @(negedge clk) if (done) done_seen++;

   // txe_mode: 0 = held low, 1 = high for 100 cycles after the first WR fall, 2 = random.
   task automatic run_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                           input int abort_byte, input int txe_mode, input int restart_at,
                           input bit time_chk);
      int nbytes, cycles, rises, done0, stall;
      logic [ADDR_W-1:0] a;
      logic [15:0] w;
      logic wprev, fell_seen;
      nbytes = (abort_byte < 0) ? 2 * int'(l) : abort_byte + 1;
      for (int i = 0; i < nbytes; i++) begin
         a = b + ADDR_W'(i / 2);
         w = word_of(a, seed);
         if (i % 2 == 0) begin
            exp_addrs.push_back(a);
            exp_bytes.push_back(w[7:0]);
         end else begin
            exp_bytes.push_back(w[15:8]);
         end
      end
      done0 = done_seen;
      @(posedge clk); #1;
      base  = b;
      len   = l;
      start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      cycles    = 0;
      rises     = 0;
      stall     = 0;
      wprev     = 1'b0;
      fell_seen = 1'b0;
      while (busy && cycles < 4000) begin
         @(posedge clk); #1;
         cycles++;
         start = 1'b0;
         abort = 1'b0;
         if (cycles == restart_at) begin
            base  = ~b;
            len   = l + ADDR_W'(1);
            start = 1'b1;
         end
         if (wr && !wprev) begin
            rises++;
            if (rises == abort_byte + 1) abort = 1'b1;
         end
         if (!wr && wprev && txe_mode == 1 && !fell_seen) begin
            fell_seen = 1'b1;
            stall     = 100;
         end
         wprev = wr;
         if (txe_mode == 1) begin
            txe = (stall > 0);
            if (stall > 0) stall--;
         end else if (txe_mode == 2) begin
            txe = ($urandom_range(0, 3) == 0);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      txe   = 1'b0;
      check("busy_falls", 64'(busy), 64'(0));
      if (time_chk) check("xfer_cycles", 64'(cycles), 64'(int'(l) * WordCyc));
      repeat (4) @(posedge clk);
      #1;
      check("idle_after", 64'(busy), 64'(0));
      check("done_pulses", 64'(done_seen - done0), 64'((abort_byte < 0) ? 1 : 0));
      check("bytes_left", 64'(exp_bytes.size()), 64'(0));
      check("addrs_left", 64'(exp_addrs.size()), 64'(0));
      exp_bytes.delete();
      exp_addrs.delete();
   endtask

   initial begin
      int ab, mode;
      logic [ADDR_W-1:0] rb, rl;
      #2;
      check("reset_state", out_vec(), RstVec);
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      repeat (3) @(posedge clk);

      // Basic two-word transfer, TXE low throughout.
      run_xfer(20'h00010, 20'd2, -1, 0, -1, 1'b1);
      // Same transfer with a 100-cycle TXE stall after the first byte.
      run_xfer(20'h00010, 20'd2, -1, 1, -1, 1'b0);

      // LEN=0: DONE the cycle after START, no SRAM or USB activity.
      @(posedge clk); #1;
      base  = 20'h00055;
      len   = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("len0_done", 64'(done), 64'(1));
      check("len0_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      check("len0_done_pulse", 64'(done), 64'(0));

      // Address wrap at the top of memory.
      run_xfer(20'hFFFFF, 20'd2, -1, 0, -1, 1'b1);
      // Abort during the first low-byte strobe.
      run_xfer(20'h00200, 20'd2, 0, 0, -1, 1'b0);

      // Reset while waiting for SRAM data.
      exp_addrs.push_back(20'h00321);
      @(posedge clk); #1;
      base  = 20'h00321;
      len   = 20'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("in_wait_ce1", 64'(ce1), 64'(0));
      rstn = 1'b0;
      #1;
      check("reset_mid_xfer", out_vec(), RstVec);
      @(negedge clk) rstn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("reset_addrs_left", 64'(exp_addrs.size()), 64'(0));
      check("reset_idle", 64'(busy), 64'(0));
      exp_addrs.delete();

      // START while busy must be ignored.
      run_xfer(20'h00100, 20'd1, -1, 0, 5, 1'b1);

      for (int n = 0; n < 8; n++) begin
         seed = 16'($urandom);
         rb   = ADDR_W'($urandom);
         rl   = ADDR_W'($urandom_range(1, 3));
         ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * int'(rl) - 2)) : -1;
         mode = int'($urandom_range(0, 2));
         run_xfer(rb, rl, ab, mode, -1, (mode == 0) && (ab < 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
